mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Iterative multiply unit and sequencer for the MIPS datapath's HI/LO registers, serving MULT/MULTU.
- Performs radix-2 shift-add multiplication over WIDTH cycles and owns the HI/LO registers.
- Drives a stall back to the main controller when a new multiply, or an MFHI/MFLO read, arrives while a multiply is in flight.
- Sits beside the ALU. The main decoder raises start for MULT/MULTU and rd_req for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  multiply request (MULT/MULTU decoded this cycle)
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU
a  input  WIDTH  multiplicand (rs), sampled only when start is accepted
b  input  WIDTH  multiplier (rt), sampled only when start is accepted
rd_req  input  1  MFHI/MFLO in decode this cycle
busy  output  1  multiply in progress
stall  output  1  freeze PC/pipeline this cycle
done  output  1  one-cycle pulse: HI/LO just updated
hi  output  WIDTH  HI register (upper product half)
lo  output  WIDTH  LO register (lower product half)

Behaviour:
- Reset (asynchronous, any time including mid-operation): state=IDLE, count=0, hi=0, lo=0, busy=0, done=0. Any in-flight product is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 at a clock edge is accepted.
  - That edge latches |a| and |b| (magnitudes if is_signed, raw otherwise) and latches neg = is_signed & (a[WIDTH-1]^b[WIDTH-1]).
  - It also clears the 2*WIDTH accumulator, sets count=0 and moves to RUN.
- RUN:
  - Each edge: if multiplier LSB=1, add the multiplicand into the accumulator upper half.
  - Shift the accumulator and multiplier right by 1 (carry kept, WIDTH+1-bit add), then count+1.
  - After the WIDTH-th step (count==WIDTH-1 at the edge), move to FIX.
- FIX:
  - One edge: {hi,lo} <= neg ? two's-complement negation of accumulator : accumulator.
  - The same edge moves to IDLE.
- busy = (state != IDLE).
- Latency: start accepted at edge E; hi/lo updated at edge E+WIDTH+1; busy high for exactly WIDTH+1 cycles.
- done: registered. High for exactly the one cycle following the FIX edge, otherwise 0.
- stall = busy & (start | rd_req). This is combinational.
  - An MFHI/MFLO or a back-to-back MULT is held until the result is in HI/LO.
  - Unrelated instructions proceed.
- Start while busy is ignored. Operands are not resampled and the request is not queued; the stalled datapath re-presents it.
- Start in the same cycle done=1 (state IDLE) is accepted normally. Back-to-back multiplies therefore have WIDTH+2 cycles of issue spacing.
- rd_req while IDLE: no stall. hi/lo hold the last result.
- hi/lo change only at the FIX edge or on reset.
- Unsigned product fits exactly in 2*WIDTH bits. Signed most-negative×most-negative (magnitude 2^(WIDTH-1) each) must yield +2^(2*WIDTH-2) without overflow.

Test Plan:
- Unsigned 7×6: start at edge 0 → busy high for 33 cycles; at edge 33 hi=0x00000000, lo=0x0000002A; done=1 for exactly cycle 33.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed cases:
  - 0xFFFFFFFF (−1)×0x00000001 → hi=0xFFFFFFFF, lo=0xFFFFFFFF.
  - 0x80000000×0x80000000 → hi=0x40000000, lo=0x00000000.
  - Same operands unsigned → hi=0x40000000, lo=0x00000000.
- Hazards:
  - Assert rd_req on cycle 5 of a multiply → stall=1 that cycle, stall=0 with rd_req in IDLE after done.
  - start again at cycle 10 with new operands → stall=1, operands ignored, result equals first multiply.
- Reset mid-operation: assert reset at cycle 12 of 3×5 → busy, done, hi and lo go 0 immediately (asynchronously). After release, a fresh 3×5 gives lo=0x0000000F 33 cycles after start.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// Decoder <-> multiply unit bundle: multiply/read requests in, stall and HI/LO out.
// Handshake: start is a request that is taken only at an edge where busy=0; while busy=1
// any start or rd_req raises stall in the same cycle and the requester must hold it.
interface mdu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rd_req;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b, rd_req,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b, rd_req,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Radix-2 shift-add multiplier owning HI/LO; signs are stripped on entry and
// reapplied in a single FIX cycle so the datapath itself is purely unsigned.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    mdu_sequencer_if.slave     bus,
    output logic [1:0]         dbg_state
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic             neg;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    fixed;

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_a = bus.a;
        mag_b = bus.b;
        if (bus.is_signed && bus.a[WIDTH-1]) mag_a = ~bus.a + WIDTH'(1);
        if (bus.is_signed && bus.b[WIDTH-1]) mag_b = ~bus.b + WIDTH'(1);
    end

    // Extra carry bit keeps the partial sum exact before it is shifted down.
    always_comb begin
        sum = {1'b0, acc[PW-1:WIDTH]};
        if (mplier[0]) sum = {1'b0, acc[PW-1:WIDTH]} + {1'b0, mcand};
    end

    always_comb begin
        fixed = acc;
        if (neg) fixed = ~acc + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    hi_r   <= fixed[PW-1:WIDTH];
                    lo_r   <= fixed[WIDTH-1:0];
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.stall = bus.busy & (bus.start | bus.rd_req);
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign dbg_state = state;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: fixed vector table, hazard/reset sequences, and random
// multiplies checked against a 64-bit arithmetic reference.
module tb_mdu_sequencer;
  localparam int W = 32;

  logic clk;
  logic reset;
  logic [1:0] dbg_state;
  int total;
  int bad;

  logic [2*W-1:0] exp_q[$];

  mdu_sequencer_if #(.WIDTH(W)) bus ();

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint sx;
    longint sy;
    logic [2*W-1:0] ux;
    logic [2*W-1:0] uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'b0, x};
    uy = {32'b0, y};
    return ux * uy;
  endfunction

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // driver: present a multiply for one edge, then scramble operands to expose missed latching
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = xa;
    bus.b = xb;
    bus.is_signed = xs;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  // counts busy cycles; returns on the first negedge with busy low (bounded)
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [2*W-1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;

    total = 0;
    bad = 0;

    vecs[0] = '{32'h0000_0007, 32'h0000_0006, 1'b0, 32'h0000_0000, 32'h0000_002A};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0000, 32'h0000_000F};
    vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'hC000_0000, 32'h8000_0000};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
    vecs[8] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h0000_0000};

    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.rd_req = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state, and rd_req while idle must not stall
    @(negedge clk);
    bus.rd_req = 1'b1;
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_stall_idle_rd", 64'(bus.stall), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    bus.rd_req = 1'b0;

    // table vectors
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_done(n);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(n), 64'd33);
      chk($sformatf("vec%0d_done", i), 64'(bus.done), 64'd1);
      chk($sformatf("vec%0d_hilo", i), {bus.hi, bus.lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      @(negedge clk);
      chk($sformatf("vec%0d_done_drop", i), 64'(bus.done), 64'd0);
    end

    // hazard: rd_req and a second start during a multiply stall; second start is dropped
    issue(32'd7, 32'd6, 1'b0);
    repeat (4) @(negedge clk);
    bus.rd_req = 1'b1;
    #1;
    chk("hz_rd_stall", 64'(bus.stall), 64'd1);
    bus.rd_req = 1'b0;
    #1;
    chk("hz_no_req_no_stall", 64'(bus.stall), 64'd0);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd99;
    bus.b = 32'd99;
    bus.is_signed = 1'b0;
    #1;
    chk("hz_start_stall", 64'(bus.stall), 64'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n);
    chk("hz_done", 64'(bus.done), 64'd1);
    chk("hz_result_first", {bus.hi, bus.lo}, 64'd42);
    bus.rd_req = 1'b1;
    #1;
    chk("hz_rd_idle_no_stall", 64'(bus.stall), 64'd0);
    bus.rd_req = 1'b0;

    // start during the done cycle is accepted immediately
    bus.start = 1'b1;
    bus.a = 32'h0001_0000;
    bus.b = 32'h0001_0000;
    bus.is_signed = 1'b1;
    #1;
    chk("b2b_no_stall", 64'(bus.stall), 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n);
    chk("b2b_busy_cycles", 64'(n), 64'd33);
    chk("b2b_result", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    @(negedge clk);
    chk("hz_idle_after", 64'(bus.busy), 64'd0);

    // asynchronous reset mid-multiply
    issue(32'd3, 32'd5, 1'b0);
    repeat (12) @(negedge clk);
    chk("rst_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(32'd3, 32'd5, 1'b0);
    wait_done(n);
    chk("rst_fresh_cycles", 64'(n), 64'd33);
    chk("rst_fresh_result", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);

    // random multiplies against the reference model, with occasional rd_req hazards
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_mul(ra, rb, rs));
      issue(ra, rb, rs);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      bus.rd_req = 1'b1;
      #1;
      chk($sformatf("rnd%0d_rd_stall", i), 64'(bus.stall), 64'(bus.busy));
      bus.rd_req = 1'b0;
      wait_done(n);
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d_done", i), 64'(bus.done), 64'd1);
      chk($sformatf("rnd%0d_hilo", i), {bus.hi, bus.lo}, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
